apb_reg_slave: RTL
==================

Name: apb_reg_slave

Overview:
APB completer (slave end) of the APB bus driven by the ICB-to-APB bridge master. It terminates APB transfers into a bank of 32-bit read/write registers, with a parameterised number of wait states. It flags out-of-range accesses and protocol violations. It serves as the bridge's downstream target in the SoC and as the reference responder in bridge verification.

Parameters:
NUM_REGS, 8, number of 32-bit registers; legal range 1..256.
BASE_ADDR, 32'h2000_0000, byte address of register 0; must be 4-byte aligned.
WAIT_CYCLES, 0, wait states inserted in each access phase before pready; legal range 0..15.
RESET_VAL, 32'h0, reset value of every register.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  asynchronous, active-high reset.
psel  input  1  APB select.
penable  input  1  APB enable (access phase).
pwrite  input  1  1 = write, 0 = read.
paddr  input  32  byte address.
pwdata  input  32  write data.
prdata  output  32  read data.
pready  output  1  transfer complete.
regs_flat  output  NUM_REGS*32  register contents; reg i is at bits [32*i+31:32*i].
err_cnt  output  16  saturating count of out-of-range accesses.
proto_err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (async assert, sync release). State goes to IDLE. Wait counter = 0. All registers = RESET_VAL. err_cnt = 0. proto_err = 0. pready = 0. prdata = 0.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS on psel=1 and penable=0 (setup phase).
  - On that edge, latch paddr, pwrite and pwdata into addr_q, wr_q and wdata_q. Clear the wait counter.
  - ACCESS: if psel=1 and penable=1 and cnt<WAIT_CYCLES, then cnt+1.
  - pready = (state==ACCESS) & (cnt==WAIT_CYCLES). This is combinational from registered state only; it has no combinational path from APB inputs.
  - ACCESS -> IDLE on the edge where psel, penable and pready are all 1. This is the completion edge.
  - ACCESS -> IDLE also if psel=0 (abort). No commit, no error count change, proto_err pulses.
- Latency: access phase lasts exactly WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0 the transfer takes the minimum 2 cycles (setup + access).
- Back-to-back: a new setup phase in the cycle after the completion edge is accepted normally.
- Decode:
  - Compute off = addr_q - BASE_ADDR; addr_q[1:0] is ignored.
  - In range iff addr_q >= BASE_ADDR and off[31:2] < NUM_REGS.
  - idx = off[31:2].
- Write: reg[idx] <= wdata_q at the completion edge if in range. Otherwise the write is dropped.
- Read: prdata = reg[idx] while pready=1 and the address is in range. prdata = 32'h0 when out of range and in every cycle with pready=0.
- A read of a register written by the immediately preceding transfer returns the new value.
- Out-of-range access (read or write) increments err_cnt at the completion edge. err_cnt saturates at 16'hFFFF and never wraps.
- proto_err pulses for one cycle after either violation:
  - psel=1 and penable=1 seen in IDLE. This is ignored and does not start a transfer.
  - psel=0 seen in ACCESS (abort).
- Reset asserted mid-transfer: immediate return to IDLE. pready drops asynchronously and no commit happens.

Test Plan:
1. WAIT_CYCLES=0. Write 32'hA5A5_1234 to 0x2000_0008, then read 0x2000_0008 -> pready high in the 2nd cycle of each transfer; prdata=32'hA5A5_1234; regs_flat[95:64]=32'hA5A5_1234.
2. WAIT_CYCLES=3. Read 0x2000_0000 after reset -> pready low for 3 access cycles, high on the 4th; prdata=0 until pready, then 32'h0 (RESET_VAL).
3. Write 0x2000_0020 (idx 8, NUM_REGS=8), then read 0x1FFF_FFFC -> both complete normally; no register changes; read prdata=0; err_cnt=2.
4. Back-to-back writes of 1, 2, 3 to idx 0, 1, 2 with no idle cycles, then reads of all three -> values 1, 2, 3 read back; each transfer takes 2 cycles; proto_err never asserts.
5. psel drops in the 2nd access cycle of a write with WAIT_CYCLES=3 -> register unchanged; proto_err pulses once; the next transfer completes normally.
6. rst asserted in the access phase of a write of 32'hFFFF_FFFF to idx 0 -> pready=0 immediately; reg0=RESET_VAL after release; FSM in IDLE.

Source files
------------

// File: rtl/apb_reg_slave.sv
// APB completer terminating transfers into a bank of 32-bit registers.
// Supports programmable wait states, out-of-range counting and protocol-violation flagging.
module apb_reg_slave #(
  parameter int unsigned NUM_REGS    = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [31:0]              paddr,
  input  logic [31:0]              pwdata,
  output logic [31:0]              prdata,
  output logic                     pready,
  output logic [NUM_REGS*32-1:0]   regs_flat,
  output logic [15:0]              err_cnt,
  output logic                     proto_err
);

  localparam int unsigned CW = 4;
  localparam int unsigned IW = 30;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_wr;
  logic [31:0]     r_regs [NUM_REGS];
  logic [15:0]     r_err_cnt;
  logic            r_proto_err;

  logic [IW-1:0]   w_idx;
  logic            w_in_range;
  logic            w_done;
  logic [31:0]     w_rdata;

  // Word index relative to the bank base; the byte offset bits drop out of the shift.
  assign w_idx      = IW'((r_addr - BASE_ADDR) >> 2);
  assign w_in_range = (r_addr >= BASE_ADDR) && (w_idx < IW'(NUM_REGS));
  assign pready     = (r_state == ACCESS) && (r_cnt == CW'(WAIT_CYCLES));
  assign w_done     = psel && penable && pready;

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == IW'(i)) w_rdata = r_regs[i];
    end
  end

  assign prdata    = (pready && w_in_range) ? w_rdata : 32'h0;
  assign err_cnt   = r_err_cnt;
  assign proto_err = r_proto_err;

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_flat[32*i +: 32] = r_regs[i];
    end
  end

  // Transfer FSM, register bank commit and error bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wr        <= 1'b0;
      r_err_cnt   <= '0;
      r_proto_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
    end else begin
      r_proto_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (psel && !penable) begin
            r_state <= ACCESS;
            r_addr  <= paddr;
            r_wr    <= pwrite;
            r_wdata <= pwdata;
            r_cnt   <= '0;
          end else if (psel && penable) begin
            r_proto_err <= 1'b1;
          end
        end
        ACCESS: begin
          if (!psel) begin
            r_state     <= IDLE;
            r_proto_err <= 1'b1;
          end else if (w_done) begin
            r_state <= IDLE;
            if (w_in_range) begin
              if (r_wr) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                  if (w_idx == IW'(i)) r_regs[i] <= r_wdata;
                end
              end
            end else if (r_err_cnt != 16'hFFFF) begin
              r_err_cnt <= r_err_cnt + 16'd1;
            end
          end else if (penable && (r_cnt < CW'(WAIT_CYCLES))) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
